// File: rtl/fp_pkg.sv
// Shared single-precision field layout, constants and accumulator FSM states.
package fp_pkg;

    localparam int FP_SIGN     = 31;
    localparam int FP_EXP_HI   = 30;
    localparam int FP_EXP_LO   = 23;
    localparam int FP_MANT_HI  = 22;
    localparam int FP_BIAS     = 127;
    localparam int FP_EXP_MAX  = 255;

    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        ROUND = 3'd4,
        OUT   = 3'd5
    } fp_state_e;

endpackage

// File: rtl/fp_lzc.sv
// Combinational 28-bit leading-zero counter; an all-zero input reports 28.
module fp_lzc (
    input  logic [27:0] din,
    output logic [4:0]  count
);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        count = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (din[i]) begin
                count = 5'(27 - i);
            end else begin
                count = count;
            end
        end
    end

endmodule

// File: rtl/fp_acc.sv
// Multi-cycle single-precision accumulator: one operand per five cycles,
// round-to-nearest-even, result handed off on the operand flagged last.
module fp_acc
    import fp_pkg::*;
#(
    parameter bit OUT_ACC_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    fp_state_e   state_r, state_next_s;

    logic [31:0] acc_r, op_r, out_data_r;
    logic        last_r, in_ready_r, out_valid_r, busy_r;
    logic [26:0] big_r, small_r;
    logic [7:0]  exp_r;
    logic        sign_r, sub_r;
    logic [27:0] sum_r, norm_r;
    logic [9:0]  nexp_r;
    logic        zero_r;

    logic        in_xfer_s, out_xfer_s;
    logic [7:0]  acc_exp_s, op_exp_s, big_exp_s, small_exp_s, diff_s;
    logic [23:0] acc_sig_s, op_sig_s, big_sig_s, small_sig_s;
    logic        swap_s, big_sign_s, small_sign_s, sticky_s;
    logic [26:0] small_ext_s, lost_mask_s, aligned_s;
    logic [27:0] sum_s, norm_s;
    logic [4:0]  lzc_s;
    logic [9:0]  nexp_s, rexp_s;
    logic [23:0] rsig_s;
    logic        round_up_s;
    logic [24:0] rsum_s;
    logic [22:0] rmant_s;
    logic [31:0] result_s;

    assign in_xfer_s  = in_valid & in_ready_r;
    assign out_xfer_s = out_valid_r & out_ready;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;

    fp_lzc u_lzc (
        .din   (sum_r),
        .count (lzc_s)
    );

    // Unpack, order by magnitude and align the smaller significand with sticky.
    always_comb begin
        acc_exp_s = acc_r[FP_EXP_HI:FP_EXP_LO];
        op_exp_s  = op_r[FP_EXP_HI:FP_EXP_LO];
        acc_sig_s = (acc_exp_s == 8'd0) ? 24'd0 : {1'b1, acc_r[FP_MANT_HI:0]};
        op_sig_s  = (op_exp_s == 8'd0) ? 24'd0 : {1'b1, op_r[FP_MANT_HI:0]};
        swap_s    = {op_exp_s, op_sig_s} > {acc_exp_s, acc_sig_s};
        if (swap_s) begin
            big_exp_s    = op_exp_s;
            big_sig_s    = op_sig_s;
            big_sign_s   = op_r[FP_SIGN];
            small_exp_s  = acc_exp_s;
            small_sig_s  = acc_sig_s;
            small_sign_s = acc_r[FP_SIGN];
        end else begin
            big_exp_s    = acc_exp_s;
            big_sig_s    = acc_sig_s;
            big_sign_s   = acc_r[FP_SIGN];
            small_exp_s  = op_exp_s;
            small_sig_s  = op_sig_s;
            small_sign_s = op_r[FP_SIGN];
        end
        diff_s      = big_exp_s - small_exp_s;
        small_ext_s = {small_sig_s, 3'b000};
        lost_mask_s = 27'd0;
        sticky_s    = 1'b0;
        if (diff_s >= 8'd27) begin
            aligned_s = {26'd0, |small_sig_s};
        end else begin
            lost_mask_s = (27'd1 << diff_s) - 27'd1;
            sticky_s    = |(small_ext_s & lost_mask_s);
            aligned_s   = (small_ext_s >> diff_s) | {26'd0, sticky_s};
        end
    end

    // Magnitude add or subtract with a carry bit on top.
    always_comb begin
        if (sub_r) begin
            sum_s = {1'b0, big_r} - {1'b0, small_r};
        end else begin
            sum_s = {1'b0, big_r} + {1'b0, small_r};
        end
    end

    // Normalise so the leading one sits in bit 27; the exponent carries a +1
    // for that frame, so the carry case needs no shift and only the increment.
    always_comb begin
        if (sum_r[27]) begin
            norm_s = sum_r;
            nexp_s = {2'b00, exp_r} + 10'd1;
        end else begin
            norm_s = sum_r << lzc_s;
            nexp_s = {2'b00, exp_r} + 10'd1 - {5'd0, lzc_s};
        end
    end

    // Round to nearest even on G/R/S below the 24-bit significand and pack.
    always_comb begin
        rsig_s     = norm_r[27:4];
        round_up_s = norm_r[3] & (norm_r[2] | (|norm_r[1:0]) | rsig_s[0]);
        rsum_s     = {1'b0, rsig_s} + {24'd0, round_up_s};
        rexp_s     = nexp_r + (rsum_s[24] ? 10'd1 : 10'd0);
        rmant_s    = rsum_s[24] ? 23'd0 : rsum_s[22:0];
        if (zero_r) begin
            result_s = FP_POS_ZERO;
        end else if ($signed(rexp_s) >= $signed(10'(FP_EXP_MAX))) begin
            result_s = {sign_r, 8'hFF, 23'd0};
        end else if ($signed(rexp_s) <= $signed(10'd0)) begin
            result_s = {sign_r, 31'd0};
        end else begin
            result_s = {sign_r, rexp_s[7:0], rmant_s};
        end
    end

    // Next-state decode of the five-step accumulate sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_xfer_s) begin
                    state_next_s = ALIGN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ALIGN: state_next_s = ADD;
            ADD:   state_next_s = NORM;
            NORM:  state_next_s = ROUND;
            ROUND: begin
                if (last_r) begin
                    state_next_s = OUT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            OUT: begin
                if (out_xfer_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = OUT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register plus handshake/status flags registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == OUT);
            busy_r      <= (state_next_s != IDLE);
        end
    end

    // Datapath pipeline registers, each stage loaded only in its own state.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r      <= FP_POS_ZERO;
            op_r       <= 32'd0;
            last_r     <= 1'b0;
            out_data_r <= 32'd0;
            big_r      <= 27'd0;
            small_r    <= 27'd0;
            exp_r      <= 8'd0;
            sign_r     <= 1'b0;
            sub_r      <= 1'b0;
            sum_r      <= 28'd0;
            norm_r     <= 28'd0;
            nexp_r     <= 10'd0;
            zero_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_xfer_s) begin
                        op_r   <= in_data;
                        last_r <= in_last;
                    end
                end
                ALIGN: begin
                    big_r   <= {big_sig_s, 3'b000};
                    small_r <= aligned_s;
                    exp_r   <= big_exp_s;
                    sign_r  <= big_sign_s;
                    sub_r   <= big_sign_s ^ small_sign_s;
                end
                ADD: begin
                    sum_r <= sum_s;
                end
                NORM: begin
                    norm_r <= norm_s;
                    nexp_r <= nexp_s;
                    zero_r <= (sum_r == 28'd0);
                end
                ROUND: begin
                    acc_r <= result_s;
                    if (last_r) begin
                        out_data_r <= result_s;
                    end
                end
                OUT: begin
                    if (out_xfer_s && OUT_ACC_CLEAR) begin
                        acc_r <= FP_POS_ZERO;
                    end
                end
                default: begin
                    acc_r <= FP_POS_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_acc.sv
// Directed bench for fp_acc: two-operand sums from a table, then
// backpressure/clear and reset-during-operation sequences.
module tb_fp_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
    } vec_t;

    vec_t vecs [14];

    fp_acc #(.OUT_ACC_CLEAR(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready, then present one operand for exactly one accepting edge.
    task automatic push(input logic [31:0] d, input logic l);
        int b = 0;
        while (!in_ready && b < 50) begin
            tick();
            b++;
        end
        if (!in_ready) begin
            check("push_ready_timeout", {31'd0, in_ready}, 32'd1);
        end else begin
            in_data  = d;
            in_last  = l;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // Cycle index (acceptance cycle = 0) at which in_ready comes back.
    task automatic wait_in_ready(output int lat);
        lat = 1;
        while (!in_ready && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    // Cycle index (acceptance cycle = 0) at which out_valid rises.
    task automatic wait_out_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic recv(output logic [31:0] d);
        d = out_data;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [31:0] d;

        vecs[0]  = '{32'h3F800000, 32'h40000000, 32'h40400000};
        vecs[1]  = '{32'h3F800000, 32'hBF800000, 32'h00000000};
        vecs[2]  = '{32'h3F800000, 32'h33800000, 32'h3F800000};
        vecs[3]  = '{32'h3F800000, 32'h33800001, 32'h3F800001};
        vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000};
        vecs[5]  = '{32'h3F800000, 32'h3F800000, 32'h40000000};
        vecs[6]  = '{32'hBF800000, 32'hC0000000, 32'hC0400000};
        vecs[7]  = '{32'h40400000, 32'hBF800000, 32'h40000000};
        vecs[8]  = '{32'h3FC00000, 32'h3E800000, 32'h3FE00000};
        vecs[9]  = '{32'h00000001, 32'h3F800000, 32'h3F800000};
        vecs[10] = '{32'h00800001, 32'h80800000, 32'h00000000};
        vecs[11] = '{32'h80800001, 32'h00800000, 32'h80000000};
        vecs[12] = '{32'h00000000, 32'h00000000, 32'h00000000};
        vecs[13] = '{32'h3F800001, 32'h33800000, 32'h3F800002};

        rst       = 1'b1;
        in_data   = 32'd0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("reset_in_ready",  {31'd0, in_ready},  32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_busy",      {31'd0, busy},      32'd0);
        check("reset_out_data",  out_data,           32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            push(vecs[i].a, 1'b0);
            wait_in_ready(lat);
            check($sformatf("vec%0d_in_ready_lat", i), lat, 32'd5);
            push(vecs[i].b, 1'b1);
            wait_out_valid(lat);
            check($sformatf("vec%0d_out_valid_lat", i), lat, 32'd5);
            recv(d);
            check($sformatf("vec%0d_sum", i), d, vecs[i].sum);
            check($sformatf("vec%0d_out_valid_drop", i), {31'd0, out_valid}, 32'd0);
        end

        // Backpressure: result held while an input is offered; no acceptance.
        push(32'h3F800000, 1'b0);
        wait_in_ready(lat);
        push(32'h40000000, 1'b1);
        wait_out_valid(lat);
        check("bp_first", out_data, 32'h40400000);
        in_data  = 32'h40000000;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("bp_hold%0d_data", k), out_data, 32'h40400000);
            check($sformatf("bp_hold%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
            check($sformatf("bp_hold%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        recv(d);
        check("bp_sum", d, 32'h40400000);
        push(32'h3F800000, 1'b1);
        wait_out_valid(lat);
        recv(d);
        check("bp_cleared_acc", d, 32'h3F800000);

        // Reset while 2.0 is in ADD on top of an accumulator holding 1.0.
        push(32'h3F800000, 1'b0);
        wait_in_ready(lat);
        push(32'h40000000, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_busy",      {31'd0, busy},      32'd0);
        check("rst_mid_out_data",  out_data,           32'd0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("rst_after%0d_out_valid", k), {31'd0, out_valid}, 32'd0);
        end
        push(32'h3F800000, 1'b1);
        wait_out_valid(lat);
        check("rst_new_lat", lat, 32'd5);
        recv(d);
        check("rst_new_sum", d, 32'h3F800000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_acc.md
# fp_acc

Sequential single-precision IEEE 754 accumulator that sits directly downstream of `fp_mul`. It consumes a stream of 32-bit products over a valid/ready handshake and sums them with round-to-nearest-even. On the operand flagged `in_last` it emits the total and clears itself for the next dot product. It is a multi-cycle FSM with one adder datapath, sized for area rather than throughput.

## Interface
- `OUT_ACC_CLEAR`, default 1: when 1 the accumulator returns to +0 after each result is handed off; when 0 it keeps the running sum.
- `clk`  in  1  the single clock; every register updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_data`  in  32  IEEE 754 single operand (sign 31, exponent 30:23, mantissa 22:0).
- `in_valid`  in  1  `in_data` and `in_last` are valid.
- `in_last`  in  1  this operand closes the current sum.
- `in_ready`  out  1  block accepts an operand this cycle.
- `out_data`  out  32  final sum.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts `out_data`.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- **Transfers.** An input transfer happens when `in_valid & in_ready`. An output transfer happens when `out_valid & out_ready`.
- **FSM states.** IDLE → ALIGN → ADD → NORM → ROUND → (IDLE | OUT). OUT → IDLE on an output transfer.
- **IDLE.**
  - `in_ready` = 1.
  - On transfer, capture the operand and the last flag, then go to ALIGN.
- **ALIGN.**
  - Unpack both the accumulator and the operand to a 24-bit significand with the hidden 1.
  - Exponent field 0 counts as zero: significand 0, denormals flushed.
  - Order the two by magnitude (exponent, then significand) and place the larger first.
  - Shift the smaller one right by the exponent difference into a 27-bit field (24 + G + R + S). Bits shifted out are ORed into S.
  - A difference of 27 or more leaves only S = (smaller ≠ 0).
- **ADD.**
  - Same signs: add. Different signs: large − small.
  - The result is 28 bits wide, including the carry.
  - The result sign is the sign of the larger operand.
- **NORM.**
  - On carry: shift right by 1 (keep S sticky) and add 1 to the exponent.
  - Otherwise: shift left by the leading-zero count from `fp_lzc` and subtract the count from the exponent.
  - A zero result gives exactly +0.
- **ROUND.**
  - Round up iff G & (R | S | lsb).
  - A mantissa carry-out adds 1 to the exponent.
  - The exponent is held in 10 bits, signed.
  - Exponent ≥ 255 → ±inf (`exp` = 0xFF, `mant` = 0).
  - Exponent ≤ 0 → signed zero (flush).
  - Write the result to the accumulator. If the last flag is set, load `out_data` and go to OUT; otherwise go to IDLE.
- **OUT.**
  - `out_valid` = 1 and `in_ready` = 0.
  - `out_data` is held stable until the output transfer.
  - On transfer, the accumulator clears to +0 if `OUT_ACC_CLEAR` = 1.
- **Out of contract.** Inputs with exponent 0xFF (inf/NaN) are not supported, same as `fp_mul`; the result is undefined but the FSM must not hang.
- **Reset.** `rst` asserted in any state, including mid-operation:
  - next cycle is IDLE with accumulator +0;
  - `out_valid` = 0, `out_data` = 0, `busy` = 0, `in_ready` = 1;
  - the in-flight operand is discarded.

## Timing
- An operand accepted in cycle t updates the accumulator at the end of cycle t+4.
- `in_ready` returns high in cycle t+5 for a non-last operand.
- For a last operand, `out_valid` rises in cycle t+5. The earliest next input acceptance is the cycle after the output transfer.
- Throughput is one operand per 5 cycles. The block never accepts input while an output is pending.
- `in_ready` is a registered function of state only; it must not depend combinationally on `in_valid`.
- `out_valid` and `out_data` are registered.
- `in_last` is sampled only on an input transfer.
- `out_ready` may be high before `out_valid` rises; the transfer then occurs in the first OUT cycle.

## Structure
- **Shared package `fp_pkg`:**
  - `FP_SIGN` = 31, `FP_EXP` = 30:23, `FP_MANT` = 22:0, `FP_BIAS` = 127;
  - `FP_EXP_MAX` = 255, `FP_POS_ZERO` = 32'h0000_0000;
  - an FSM state enum (IDLE, ALIGN, ADD, NORM, ROUND, OUT).
- **Sub-module `fp_lzc`:** a combinational 28-bit leading-zero counter with a 5-bit count output. Count = 28 for an all-zero input.

## Test plan
- **Simple sum.** Feed 0x3F800000 (1.0), then 0x40000000 (2.0) with `in_last`. Expect `out_data` = 0x40400000 (3.0), with `out_valid` 5 cycles after the second acceptance.
- **Exact cancellation.** Feed 0x3F800000, then 0xBF800000 with last. Expect 0x00000000 (+0).
- **Round-to-even tie.** Feed 0x3F800000, then 0x33800000 (2^-24) with last. Expect 0x3F800000.
- **Round up and overflow.**
  - Feed 0x3F800000, then 0x33800001 with last. Expect 0x3F800001.
  - Feed 0x7F7FFFFF, then 0x7F7FFFFF with last. Expect 0x7F800000.
- **Backpressure and clear.**
  - Hold `out_ready` = 0 for 3 cycles after a result of 3.0. Expect `out_data` stable, `in_ready` = 0, no input accepted.
  - Then feed 0x3F800000 with last. Expect 0x3F800000, confirming the accumulator was cleared.
- **Reset mid-operation.** Assert `rst` during ADD of 0x40000000 on an accumulator holding 1.0. Then feed 0x3F800000 with last. Expect 0x3F800000; `out_valid` stays 0 during and after reset until the new result.
